q_update_engine: RTL

Q_UPDATE_ENGINE -- requirements
Module: q_update_engine

---
 rtl/q_update_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/q_update_engine.sv
`default_nettype none
// ============================================================================
//  Module   : q_update_engine
//  Purpose  : Single tabular Q-learning update. Captures (action, reward, Q),
//             streams the next-state Q row to find its signed max/argmax,
//             then computes
//                Q' = Q + alpha * (r + gamma * max(Q(s',.)) - Q)
//             with alpha = 2^-ALPHA_SHIFT, gamma = 1 - 2^-GAMMA_SHIFT.
//  Options  : Q_TERMINAL_EN adds start_terminal; a terminal transition skips
//             the row stream and uses max = 0.
//  Revision : 1.0 - initial release
// ============================================================================
module q_update_engine #(
   parameter int N_ACTIONS   = 9,
   parameter int DATA_W      = 16,
   parameter int REWARD_W    = 8,
   parameter int ALPHA_SHIFT = 1,
   parameter int GAMMA_SHIFT = 3,
   localparam int AW         = $clog2(N_ACTIONS)
) (
   input  logic              clock,
   input  logic              reset_n,
   // transaction start
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [AW-1:0]     start_action,
   input  logic [REWARD_W-1:0] start_reward,
   input  logic [DATA_W-1:0] start_q,
`ifdef Q_TERMINAL_EN
   input  logic              start_terminal,
`endif
   // next-state row stream
   input  logic              qn_valid,
   output logic              qn_ready,
   input  logic [DATA_W-1:0] qn_data,
   // result
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_q_new,
   output logic [DATA_W-1:0] out_q_max,
   output logic [AW-1:0]     out_argmax,
   output logic [AW-1:0]     out_action,
   output logic              busy
);

   localparam int            IW        = DATA_W + 2;
   localparam logic [AW-1:0] LAST_BEAT = AW'(N_ACTIONS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      CALC   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state, state_next;

   logic [AW-1:0]              beat_cnt;
   logic [AW-1:0]              act_r;
   logic [AW-1:0]              arg_r;
   logic signed [REWARD_W-1:0] reward_r;
   logic signed [DATA_W-1:0]   q_cur;
   logic signed [DATA_W-1:0]   q_max;
   logic signed [DATA_W-1:0]   q_new_r;

   logic start_fire;
   logic beat_fire;
   logic is_better;
   logic terminal_in;

   logic signed [IW-1:0] qmax_ext;
   logic signed [IW-1:0] q_ext;
   logic signed [IW-1:0] reward_ext;
   logic signed [IW-1:0] discounted;
   logic signed [IW-1:0] delta;

`ifdef Q_TERMINAL_EN
   assign terminal_in = start_terminal;
`else
   assign terminal_in = 1'b0;
`endif

   assign start_fire = start_valid && start_ready;
   assign beat_fire  = qn_valid && qn_ready;
   // First beat always seeds the max; later beats replace only when strictly
   // greater, so ties keep the lowest index.
   assign is_better  = (beat_cnt == '0) || ($signed(qn_data) > q_max);

   // Arithmetic runs two bits wider than the data so r + g - q cannot wrap.
   assign qmax_ext   = {{2{q_max[DATA_W-1]}}, q_max};
   assign q_ext      = {{2{q_cur[DATA_W-1]}}, q_cur};
   assign reward_ext = {{(IW-REWARD_W){reward_r[REWARD_W-1]}}, reward_r};
   assign discounted = qmax_ext - (qmax_ext >>> GAMMA_SHIFT);
   assign delta      = reward_ext + discounted - q_ext;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_next  = state;
      start_ready = 1'b0;
      qn_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) begin
               state_next = terminal_in ? CALC : STREAM;
            end
         end
         STREAM: begin
            qn_ready = 1'b1;
            if (qn_valid && (beat_cnt == LAST_BEAT)) begin
               state_next = CALC;
            end
         end
         CALC: begin
            state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: capture on start, running max during the stream, result in CALC.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt <= '0;
         act_r    <= '0;
         arg_r    <= '0;
         reward_r <= '0;
         q_cur    <= '0;
         q_max    <= '0;
         q_new_r  <= '0;
      end else begin
         if (start_fire) begin
            act_r    <= start_action;
            reward_r <= start_reward;
            q_cur    <= start_q;
            beat_cnt <= '0;
            // Zero seed doubles as the terminal-transition max/argmax.
            q_max    <= '0;
            arg_r    <= '0;
         end else if (beat_fire) begin
            if (is_better) begin
               q_max <= qn_data;
               arg_r <= beat_cnt;
            end
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (state == CALC) begin
            q_new_r <= DATA_W'(q_ext + (delta >>> ALPHA_SHIFT));
         end
      end
   end

   assign out_q_new  = q_new_r;
   assign out_q_max  = q_max;
   assign out_argmax = arg_r;
   assign out_action = act_r;

endmodule
`default_nettype wire
